// File: rtl/stopwatch_ctrl_if.sv
// Button-level and control-output bundle between the debounce stages,
// the stopwatch mode controller and the BCD counter / display path.
interface stopwatch_ctrl_if;
    logic       pb_start;     // debounced start/stop level, 1 = pressed
    logic       pb_lap;       // debounced lap/reset level, 1 = pressed
    logic       count_en;     // counter increments while high
    logic       count_clr;    // one-cycle synchronous clear pulse
    logic       disp_freeze;  // display holds its latched value while high
    logic [1:0] state;        // 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP

    // Controller side: consumes button levels, produces control outputs.
    modport slave (
        input  pb_start,
        input  pb_lap,
        output count_en,
        output count_clr,
        output disp_freeze,
        output state
    );

    // Stimulus / button side: drives levels, observes control outputs.
    modport master (
        output pb_start,
        output pb_lap,
        input  count_en,
        input  count_clr,
        input  disp_freeze,
        input  state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: turns two debounced button levels into press
// events, times long holds on the lap button and sequences a 4-state mode
// FSM that drives counter enable, counter clear and display freeze.
module stopwatch_ctrl #(
    parameter int unsigned LONG_PRESS = 200,  // lap hold length (cycles) that clears from PAUSE, >= 2
    parameter int unsigned CNT_W      = 8     // hold counter width, 2**CNT_W > LONG_PRESS
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_ctrl_if.slave   sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // Saturation value and the count seen on the edge of the LONG_PRESS-th
    // high cycle (the counter lags the level by one edge).
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS);
    localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_PRESS - 1);

    logic             start_prev;
    logic             lap_prev;
    logic [CNT_W-1:0] hold_cnt;

    logic             start_evt;
    logic             lap_evt;
    logic             long_evt;

    state_t           state_q;
    state_t           state_d;
    logic             count_en_q;
    logic             count_clr_q;
    logic             disp_freeze_q;

    // Previous-level registers for rising-edge detection of both buttons.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b0;
            lap_prev   <= 1'b0;
        end else begin
            start_prev <= sw.pb_start;
            lap_prev   <= sw.pb_lap;
        end
    end

    // One-cycle press events; a level already high out of reset fires once.
    assign start_evt = sw.pb_start & ~start_prev;
    assign lap_evt   = sw.pb_lap   & ~lap_prev;

    // Lap hold timer: counts consecutive high cycles in any state and
    // saturates so the long-press event can fire only once per hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!sw.pb_lap) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    assign long_evt = sw.pb_lap & (hold_cnt == HOLD_FIRE);

    // Next-mode decode; start/stop always wins over lap and long-press.
    // NOTE: state_d is defaulted first so every path assigns it and no latch
    // is inferred from the incomplete if/else chains below.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_evt) state_d = RUN;
            end
            RUN: begin
                if (start_evt)    state_d = PAUSE;
                else if (lap_evt) state_d = LAP;
            end
            LAP: begin
                if (start_evt)    state_d = PAUSE;
                else if (lap_evt) state_d = RUN;
            end
            PAUSE: begin
                if (start_evt)     state_d = RUN;
                else if (long_evt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mode register with outputs registered from the next mode, so outputs
    // change on the same edge as the mode itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_en_q    <= 1'b0;
            count_clr_q   <= 1'b0;
            disp_freeze_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_en_q    <= (state_d == RUN)   || (state_d == LAP);
            disp_freeze_q <= (state_d == PAUSE) || (state_d == LAP);
            count_clr_q   <= (state_q == PAUSE) && (state_d == IDLE);
        end
    end

    assign sw.state       = state_q;
    assign sw.count_en    = count_en_q;
    assign sw.count_clr   = count_clr_q;
    assign sw.disp_freeze = disp_freeze_q;

endmodule
